// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side write port and FWFT read port of the rx byte FIFO
interface uart_rx_fifo_if #(parameter int DEPTH = 16);
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic                     rx_ferr;
  logic [7:0]               rd_data;
  logic                     rd_ferr;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [$clog2(DEPTH):0]   level;
  logic                     overrun;
  logic                     ovr_clr;
  logic                     idle;
  modport master (
    output rx_data, rx_valid, rx_ferr, rd_ready, ovr_clr,
    input  rd_data, rd_ferr, rd_valid, level, overrun, idle
  );
  modport slave (
    input  rx_data, rx_valid, rx_ferr, rd_ready, ovr_clr,
    output rd_data, rd_ferr, rd_valid, level, overrun, idle
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte FIFO behind the UART receiver with overrun and idle-line flags
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int IDLE_CYCLES = 160,
  parameter bit DROP_FERR   = 1'b0
) (
  input logic            i_clk,
  input logic            i_rst_n,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(IDLE_CYCLES + 1);
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [CW-1:0] r_idle_cnt;
  logic          r_overrun, r_idle;
  logic          w_full, w_empty, w_rd, w_drop_ferr, w_wr, w_ovr_set;
  logic [LW-1:0] w_level_nxt;
  logic [CW-1:0] w_cnt_nxt;
  assign w_full      = r_level == LW'(DEPTH);
  assign w_empty     = r_level == '0;
  assign w_rd        = bus.rd_ready & ~w_empty;
  assign w_drop_ferr = DROP_FERR & bus.rx_ferr;
  // a full FIFO still accepts when the same-cycle read frees the head slot
  assign w_wr        = bus.rx_valid & ~w_drop_ferr & (~w_full | w_rd);
  assign w_ovr_set   = bus.rx_valid & ~w_drop_ferr & w_full & ~w_rd;
  assign w_level_nxt = r_level + LW'(w_wr) - LW'(w_rd);
  // idle counter restarts on any accepted byte or an empty FIFO, saturates otherwise
  always_comb
    w_cnt_nxt = (w_wr || w_empty) ? '0 : (r_idle_cnt == CW'(IDLE_CYCLES)) ? r_idle_cnt : r_idle_cnt + 1'b1;
  // storage is deliberately left unreset; only pointers define valid contents
  always_ff @(posedge i_clk)
    if (w_wr) r_mem[r_wr_ptr] <= {bus.rx_ferr, bus.rx_data};
  // pointers, occupancy and status flags
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_idle_cnt <= '0;
      r_overrun  <= 1'b0;
      r_idle     <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + AW'(w_wr);
      r_rd_ptr   <= r_rd_ptr + AW'(w_rd);
      r_level    <= w_level_nxt;
      r_idle_cnt <= w_cnt_nxt;
      r_overrun  <= w_ovr_set | (r_overrun & ~bus.ovr_clr);
      r_idle     <= (w_cnt_nxt == CW'(IDLE_CYCLES)) && (w_level_nxt != '0);
    end
  assign bus.rd_valid = ~w_empty;
  assign bus.rd_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr][7:0];
  assign bus.rd_ferr  = ~w_empty & r_mem[r_rd_ptr][8];
  assign bus.level    = r_level;
  assign bus.overrun  = r_overrun;
  assign bus.idle     = r_idle;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  uart_rx_fifo_if #(.DEPTH(16)) a ();
  uart_rx_fifo_if #(.DEPTH(16)) b ();
  uart_rx_fifo #(.DEPTH(16), .IDLE_CYCLES(8), .DROP_FERR(1'b0)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(a));
  uart_rx_fifo #(.DEPTH(16), .IDLE_CYCLES(8), .DROP_FERR(1'b1)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d, input logic f = 1'b0);
    a.rx_data = d; a.rx_ferr = f; a.rx_valid = 1'b1;
    tick();
    a.rx_valid = 1'b0; a.rx_ferr = 1'b0;
  endtask
  task automatic rd();
    a.rd_ready = 1'b1;
    tick();
    a.rd_ready = 1'b0;
  endtask
  initial begin
    a.rx_data = 8'h00; a.rx_valid = 1'b0; a.rx_ferr = 1'b0; a.rd_ready = 1'b0; a.ovr_clr = 1'b0;
    b.rx_data = 8'h00; b.rx_valid = 1'b0; b.rx_ferr = 1'b0; b.rd_ready = 1'b0; b.ovr_clr = 1'b0;
    // reset state
    tick(); tick();
    chk("rst_level", 32'(a.level), 0);
    chk("rst_valid", 32'(a.rd_valid), 0);
    chk("rst_data", 32'(a.rd_data), 0);
    chk("rst_ovr", 32'(a.overrun), 0);
    chk("rst_idle", 32'(a.idle), 0);
    rst_n = 1'b1;
    tick();
    // basic FWFT
    wr(8'hA5);
    chk("fwft_valid", 32'(a.rd_valid), 1);
    chk("fwft_data", 32'(a.rd_data), 32'hA5);
    chk("fwft_level1", 32'(a.level), 1);
    repeat (9) tick();
    wr(8'h3C);
    chk("two_level", 32'(a.level), 2);
    chk("two_head", 32'(a.rd_data), 32'hA5);
    rd();
    chk("pop_data", 32'(a.rd_data), 32'h3C);
    chk("pop_level", 32'(a.level), 1);
    rd();
    chk("pop_empty_level", 32'(a.level), 0);
    chk("pop_empty_data", 32'(a.rd_data), 0);
    rd();
    chk("rd_when_empty", 32'(a.level), 0);
    // fill, overrun, drain
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("full_level", 32'(a.level), 16);
    chk("full_ovr0", 32'(a.overrun), 0);
    wr(8'hFF);
    chk("drop_level", 32'(a.level), 16);
    chk("drop_ovr", 32'(a.overrun), 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(a.rd_data), 32'(i));
      rd();
    end
    chk("drain_valid", 32'(a.rd_valid), 0);
    chk("drain_data0", 32'(a.rd_data), 0);
    chk("ovr_sticky", 32'(a.overrun), 1);
    a.ovr_clr = 1'b1; tick(); a.ovr_clr = 1'b0;
    chk("ovr_clr", 32'(a.overrun), 0);
    // full with simultaneous read and write
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
    a.rx_data = 8'h77; a.rx_valid = 1'b1; a.rd_ready = 1'b1;
    tick();
    a.rx_valid = 1'b0; a.rd_ready = 1'b0;
    chk("fullrw_level", 32'(a.level), 16);
    chk("fullrw_ovr", 32'(a.overrun), 0);
    for (int i = 1; i < 16; i++) begin
      chk("fullrw_data", 32'(a.rd_data), 32'(8'h10 + i));
      rd();
    end
    chk("fullrw_last", 32'(a.rd_data), 32'h77);
    rd();
    chk("fullrw_empty", 32'(a.level), 0);
    // set wins over clear
    for (int i = 0; i < 16; i++) wr(8'(i));
    a.rx_data = 8'hEE; a.rx_valid = 1'b1; a.ovr_clr = 1'b1;
    tick();
    a.rx_valid = 1'b0; a.ovr_clr = 1'b0;
    chk("set_wins", 32'(a.overrun), 1);
    a.ovr_clr = 1'b1; tick(); a.ovr_clr = 1'b0;
    chk("clr_after", 32'(a.overrun), 0);
    repeat (16) rd();
    chk("clr_drain", 32'(a.level), 0);
    // wrap-around with overlapping write/read pairs
    wr(8'd0);
    for (int i = 1; i < 40; i++) begin
      chk("wrap_data", 32'(a.rd_data), 32'(i - 1));
      a.rx_data = 8'(i); a.rx_valid = 1'b1; a.rd_ready = 1'b1;
      tick();
      a.rx_valid = 1'b0; a.rd_ready = 1'b0;
      chk("wrap_level", 32'(a.level), 1);
    end
    chk("wrap_last", 32'(a.rd_data), 39);
    rd();
    chk("wrap_empty", 32'(a.level), 0);
    // frame error tag, stored
    wr(8'h55, 1'b1);
    chk("ferr_keep_data", 32'(a.rd_data), 32'h55);
    chk("ferr_keep_tag", 32'(a.rd_ferr), 1);
    chk("ferr_keep_level", 32'(a.level), 1);
    rd();
    chk("ferr_empty_tag", 32'(a.rd_ferr), 0);
    // frame error tag, dropped
    b.rx_data = 8'h55; b.rx_ferr = 1'b1; b.rx_valid = 1'b1;
    tick();
    b.rx_valid = 1'b0; b.rx_ferr = 1'b0;
    chk("ferr_drop_level", 32'(b.level), 0);
    chk("ferr_drop_ovr", 32'(b.overrun), 0);
    chk("ferr_drop_valid", 32'(b.rd_valid), 0);
    b.rx_data = 8'h12; b.rx_valid = 1'b1;
    tick();
    b.rx_valid = 1'b0;
    chk("ferr_drop_good", 32'(b.rd_data), 32'h12);
    // idle detection
    wr(8'h01);
    chk("idle_after_wr", 32'(a.idle), 0);
    repeat (7) tick();
    chk("idle_7", 32'(a.idle), 0);
    tick();
    chk("idle_8", 32'(a.idle), 1);
    wr(8'h02);
    chk("idle_wr_drop", 32'(a.idle), 0);
    repeat (8) tick();
    chk("idle_again", 32'(a.idle), 1);
    rd();
    chk("idle_read_keeps", 32'(a.idle), 1);
    rd();
    chk("idle_empty_drop", 32'(a.idle), 0);
    // async reset mid-operation
    for (int i = 0; i < 5; i++) wr(8'(8'h30 + i));
    chk("pre_rst_level", 32'(a.level), 5);
    repeat (8) tick();
    chk("pre_rst_idle", 32'(a.idle), 1);
    rst_n = 1'b0;
    #1;
    chk("async_level", 32'(a.level), 0);
    chk("async_valid", 32'(a.rd_valid), 0);
    chk("async_idle", 32'(a.idle), 0);
    chk("async_data", 32'(a.rd_data), 0);
    tick();
    rst_n = 1'b1;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer sitting directly downstream of the UART receiver. Captures each byte the receiver completes, together with its frame-error tag, into a circular FIFO. Presents bytes to the consumer with a first-word-fall-through valid/ready read port. Reports overrun (sticky) and an idle-line flag for packet-gap detection.

Parameters:
DEPTH, 16, number of entries; power of 2, >= 2
IDLE_CYCLES, 160, CLK cycles with no accepted write, while non-empty, before idle asserts; >= 1
DROP_FERR, 0, 1 = discard bytes flagged with a frame error; 0 = store them with the tag

Ports:
CLK  in  1  system clock, rising-edge
RST_N  in  1  asynchronous active-low reset
rx_data  in  8  byte from receiver, qualified by rx_valid
rx_valid  in  1  single-cycle pulse, byte complete
rx_ferr  in  1  stop-bit/frame error for this byte, qualified by rx_valid
rd_data  out  8  head-of-FIFO byte; 0 when empty
rd_ferr  out  1  frame-error tag of head byte; 0 when empty
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  consumer accepts head when rd_valid & rd_ready
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overrun  out  1  sticky: a byte was dropped because the FIFO was full
ovr_clr  in  1  synchronous clear of overrun
idle  out  1  no new byte for IDLE_CYCLES while data is pending

Behaviour:
- Reset (RST_N low, async): wr_ptr = rd_ptr = 0, level = 0, rd_valid = 0, rd_data = 0, rd_ferr = 0, overrun = 0, idle = 0, idle counter = 0. Storage array is not reset. Deassertion takes effect at the next CLK edge.
- Reset mid-operation discards all buffered bytes. Any rx_valid pulse coinciding with reset is lost.
- Write: rx_valid = 1 and not dropped → {rx_ferr, rx_data} written at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap); level + 1.
- Drop conditions, no state change except as stated:
  - DROP_FERR = 1 and rx_ferr = 1 → byte discarded silently; overrun unaffected.
  - FIFO full (level = DEPTH) and no read this cycle → byte discarded; overrun set.
- Read: rd_valid & rd_ready → rd_ptr increments modulo DEPTH; level − 1. rd_ready while empty is ignored.
- FWFT latency: byte written at edge k appears on rd_data/rd_valid after edge k, so it is readable in cycle k+1. rd_data/rd_ferr are a combinational mux of mem[rd_ptr], forced to 0 when level = 0.
- Simultaneous write and read:
  - Both take effect; level unchanged.
  - When full, the read frees the slot, the write is accepted, and overrun is not set.
  - When empty, no read occurs (rd_valid = 0); the write is accepted.
- overrun:
  - Set on a dropped-full write.
  - Cleared by ovr_clr at the next edge.
  - If set and clear occur in the same cycle, set wins (overrun = 1).
- Idle counter:
  - Resets to 0 on every accepted write and whenever level = 0.
  - Otherwise increments each cycle, saturating at IDLE_CYCLES.
  - idle = (counter = IDLE_CYCLES) & (level != 0), registered.
  - idle drops the cycle after the FIFO empties or after an accepted write.
  - Reads alone do not restart the counter.
- level is registered and is never < 0 or > DEPTH. rd_valid = (level != 0).

Test Plan:
- Reset, then write 0xA5, 0x3C on rx_valid pulses 10 cycles apart, rd_ready = 0 → level = 2, rd_data = 0xA5, rd_valid = 1 from the cycle after the first write; pulse rd_ready → rd_data = 0x3C, level = 1.
- Write 16 bytes 0x00..0x0F (DEPTH = 16), then 0xFF with no read → level = 16, 0xFF dropped, overrun = 1. Drain all → reads 0x00..0x0F in order, rd_valid = 0, rd_data = 0. Assert ovr_clr → overrun = 0.
- FIFO full, rx_valid with 0x77 and rd_ready same cycle → level stays 16, overrun = 0, 0x77 read last. Separately, ovr_clr coincident with a dropped write → overrun = 1.
- Wrap-around: 40 interleaved write/read pairs with data = index → reads match 0..39, level ≤ 2 throughout, pointers wrap correctly.
- rx_ferr = 1 with 0x55:
  - DROP_FERR = 0 → stored, rd_ferr = 1.
  - DROP_FERR = 1 → level unchanged, overrun = 0.
- IDLE_CYCLES = 8: write 1 byte, hold rd_ready = 0 → idle = 1 after 8 cycles. A new write deasserts idle next cycle; reading to empty deasserts it. Assert RST_N low while level = 5 → level = 0, rd_valid = 0, idle = 0 immediately.
